// File: rtl/dependency_tracker_if.sv
// rtl/dependency_tracker_if.sv - ID-side hazard bus between decoder, tracker and EXE operand muxes
package dependency_tracker_pkg;
    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;
endpackage

interface dependency_tracker_if
    import dependency_tracker_pkg::*;
#(
    parameter int RW = 5
) ();
    logic          id_valid_i;
    logic [RW-1:0] id_src_reg_1_i;
    logic [RW-1:0] id_src_reg_2_i;
    logic          id_use_src_1_i;
    logic          id_use_src_2_i;
    logic [RW-1:0] id_dst_reg_i;
    logic          id_reg_write_enable_i;
    logic          id_is_load_i;
    logic          hold_i;
    logic          flush_i;
    logic          stall_o;
    logic [1:0]    fwd_sel_1_o;
    logic [1:0]    fwd_sel_2_o;
    bypass_t       exe_bypass_o;
    logic          exe_valid_o;

    modport master (
        output id_valid_i, id_src_reg_1_i, id_src_reg_2_i, id_use_src_1_i, id_use_src_2_i,
               id_dst_reg_i, id_reg_write_enable_i, id_is_load_i, hold_i, flush_i,
        input  stall_o, fwd_sel_1_o, fwd_sel_2_o, exe_bypass_o, exe_valid_o
    );

    modport slave (
        input  id_valid_i, id_src_reg_1_i, id_src_reg_2_i, id_use_src_1_i, id_use_src_2_i,
               id_dst_reg_i, id_reg_write_enable_i, id_is_load_i, hold_i, flush_i,
        output stall_o, fwd_sel_1_o, fwd_sel_2_o, exe_bypass_o, exe_valid_o
    );
endinterface

// File: rtl/dependency_tracker.sv
// rtl/dependency_tracker.sv - load-use stall and EXE forwarding selects from in-flight writers
module dependency_tracker
    import dependency_tracker_pkg::*;
#(
    parameter int ARCH_LEN     = 32,
    parameter int REG_FILE_LEN = 32
) (
    input logic                clk,
    input logic                rst,
    dependency_tracker_if.slave bus
);
    localparam int RW = $clog2(REG_FILE_LEN);

    if (ARCH_LEN < 1 || REG_FILE_LEN < 2) begin : g_bad_param
        $error("dependency_tracker: invalid ARCH_LEN/REG_FILE_LEN");
    end

    // Entries keep "is a writer" (valid & we & dst != 0) rather than raw write-enable.
    logic          e_valid, e_wr, e_late;
    logic [RW-1:0] e_dst;
    logic          m_wr, m_late;
    logic [RW-1:0] m_dst;
    logic          w_wr, w_late;
    logic [RW-1:0] w_dst;

    logic [1:0]    sel_1_q, sel_2_q;
    bypass_t       bypass_q;

    function automatic logic hit(input logic use_src, input logic [RW-1:0] src,
                                 input logic wr, input logic [RW-1:0] dst);
        return use_src && (src != '0) && wr && (src == dst);
    endfunction

    logic       e1, e2, m1, m2, w1, w2;
    logic       late_1, late_2;
    logic       stall;
    logic       issue;
    logic [1:0] sel_1, sel_2;

    always_comb begin
        e1 = hit(bus.id_use_src_1_i, bus.id_src_reg_1_i, e_wr, e_dst);
        e2 = hit(bus.id_use_src_2_i, bus.id_src_reg_2_i, e_wr, e_dst);
        m1 = hit(bus.id_use_src_1_i, bus.id_src_reg_1_i, m_wr, m_dst);
        m2 = hit(bus.id_use_src_2_i, bus.id_src_reg_2_i, m_wr, m_dst);
        w1 = hit(bus.id_use_src_1_i, bus.id_src_reg_1_i, w_wr, w_dst);
        w2 = hit(bus.id_use_src_2_i, bus.id_src_reg_2_i, w_wr, w_dst);

        // The youngest producer decides both the select and whether its data is late.
        late_1 = e1 ? e_late : (m1 & m_late);
        late_2 = e2 ? e_late : (m2 & m_late);
        stall  = bus.id_valid_i & ~bus.flush_i & (late_1 | late_2);
        issue  = bus.id_valid_i & ~stall & ~bus.flush_i;

        // A load that stalled its consumer is sitting in WB at issue and still uses the WB path.
        sel_1 = e1 ? 2'd1 : ((m1 | (w1 & w_late)) ? 2'd2 : 2'd0);
        sel_2 = e2 ? 2'd1 : ((m2 | (w2 & w_late)) ? 2'd2 : 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid  <= 1'b0;
            e_wr     <= 1'b0;
            e_late   <= 1'b0;
            e_dst    <= '0;
            m_wr     <= 1'b0;
            m_late   <= 1'b0;
            m_dst    <= '0;
            w_wr     <= 1'b0;
            w_late   <= 1'b0;
            w_dst    <= '0;
            sel_1_q  <= 2'd0;
            sel_2_q  <= 2'd0;
            bypass_q <= '0;
        end else if (!bus.hold_i) begin
            w_wr   <= m_wr;
            w_late <= m_late;
            w_dst  <= m_dst;
            m_wr   <= e_wr;
            m_late <= e_late;
            m_dst  <= e_dst;
            if (issue) begin
                e_valid           <= 1'b1;
                e_wr              <= bus.id_reg_write_enable_i & (bus.id_dst_reg_i != '0);
                e_late            <= bus.id_is_load_i;
                e_dst             <= bus.id_dst_reg_i;
                sel_1_q           <= sel_1;
                sel_2_q           <= sel_2;
                bypass_q.dep_src1 <= (sel_1 != 2'd0);
                bypass_q.dep_src2 <= (sel_2 != 2'd0);
            end else begin
                e_valid  <= 1'b0;
                e_wr     <= 1'b0;
                e_late   <= 1'b0;
                e_dst    <= '0;
                sel_1_q  <= 2'd0;
                sel_2_q  <= 2'd0;
                bypass_q <= '0;
            end
        end
    end

    assign bus.stall_o      = stall;
    assign bus.fwd_sel_1_o  = sel_1_q;
    assign bus.fwd_sel_2_o  = sel_2_q;
    assign bus.exe_bypass_o = bypass_q;
    assign bus.exe_valid_o  = e_valid;
endmodule

// File: tb/tb_dependency_tracker.sv
// tb/tb_dependency_tracker.sv - scoreboard bench for dependency_tracker with directed vectors
module tb_dependency_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dependency_tracker_if #(.RW(5)) bus ();

    dependency_tracker #(.ARCH_LEN(32), .REG_FILE_LEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic       stall;
        logic       ev;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: each cycle's outputs are compared half a cycle after the inputs settle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".stall"},     int'(bus.stall_o),               int'(e.stall));
            chk({e.tag, ".exe_valid"}, int'(bus.exe_valid_o),           int'(e.ev));
            chk({e.tag, ".sel1"},      int'(bus.fwd_sel_1_o),           int'(e.s1));
            chk({e.tag, ".sel2"},      int'(bus.fwd_sel_2_o),           int'(e.s2));
            chk({e.tag, ".byp1"},      int'(bus.exe_bypass_o.dep_src1), int'(e.s1 != 2'd0));
            chk({e.tag, ".byp2"},      int'(bus.exe_bypass_o.dep_src2), int'(e.s2 != 2'd0));
        end
    end

    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic we, input logic ld,
                       input logic hd, input logic fl,
                       input logic e_st, input logic e_ev, input logic [1:0] e_s1, input logic [1:0] e_s2);
        exp_t e;
        bus.id_valid_i            = v;
        bus.id_src_reg_1_i        = s1;
        bus.id_use_src_1_i        = u1;
        bus.id_src_reg_2_i        = s2;
        bus.id_use_src_2_i        = u2;
        bus.id_dst_reg_i          = d;
        bus.id_reg_write_enable_i = we;
        bus.id_is_load_i          = ld;
        bus.hold_i                = hd;
        bus.flush_i               = fl;
        e.tag = tag; e.stall = e_st; e.ev = e_ev; e.s1 = e_s1; e.s2 = e_s2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag, input logic e_ev, input logic [1:0] e_s1, input logic [1:0] e_s2);
        cyc(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_ev, e_s1, e_s2);
    endtask

    initial begin
        bus.id_valid_i            = 1'b1;
        bus.id_src_reg_1_i        = 5'd5;
        bus.id_use_src_1_i        = 1'b1;
        bus.id_src_reg_2_i        = 5'd0;
        bus.id_use_src_2_i        = 1'b0;
        bus.id_dst_reg_i          = 5'd0;
        bus.id_reg_write_enable_i = 1'b0;
        bus.id_is_load_i          = 1'b0;
        bus.hold_i                = 1'b0;
        bus.flush_i               = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state, then back-to-back ALU dependency on both sources
        cyc("rst_first", 1, 5,1, 0,0, 5,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("alu_use",   1, 5,1, 5,1, 6,1,0, 0,0, 0,1,2'd0,2'd0);
        nop("alu_exe", 1, 2'd1, 2'd1);
        nop("alu_c1",  0, 2'd0, 2'd0);
        nop("alu_c2",  0, 2'd0, 2'd0);

        // two writers of x5: E wins
        cyc("pri_a",   1, 1,1, 0,0, 5,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("pri_b",   1, 1,1, 0,0, 5,1,0, 0,0, 0,1,2'd0,2'd0);
        cyc("pri_use", 1, 5,1, 3,1, 7,1,0, 0,0, 0,1,2'd0,2'd0);
        nop("pri_exe", 1, 2'd1, 2'd0);
        nop("pri_c1",  0, 2'd0, 2'd0);
        nop("pri_c2",  0, 2'd0, 2'd0);

        // distance 2 -> MEM path
        cyc("d2_prod", 1, 1,1, 0,0, 5,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("d2_gap", 1, 2'd0, 2'd0);
        cyc("d2_use",  1, 5,1, 3,1, 7,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("d2_exe", 1, 2'd2, 2'd0);
        nop("d2_c1",  0, 2'd0, 2'd0);
        nop("d2_c2",  0, 2'd0, 2'd0);

        // distance 3 ALU -> register file
        cyc("d3_prod", 1, 1,1, 0,0, 5,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("d3_gap1", 1, 2'd0, 2'd0);
        nop("d3_gap2", 0, 2'd0, 2'd0);
        cyc("d3_use",  1, 5,1, 3,1, 7,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("d3_exe", 1, 2'd0, 2'd0);
        nop("d3_c1",  0, 2'd0, 2'd0);
        nop("d3_c2",  0, 2'd0, 2'd0);

        // load-use: two stalls then WB select
        cyc("lu_load", 1, 1,1, 0,0, 7,1,1, 0,0, 0,0,2'd0,2'd0);
        cyc("lu_st1",  1, 7,1, 1,1, 8,1,0, 0,0, 1,1,2'd0,2'd0);
        cyc("lu_st2",  1, 7,1, 1,1, 8,1,0, 0,0, 1,0,2'd0,2'd0);
        cyc("lu_iss",  1, 7,1, 1,1, 8,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("lu_exe", 1, 2'd2, 2'd0);
        nop("lu_c1",  0, 2'd0, 2'd0);
        nop("lu_c2",  0, 2'd0, 2'd0);

        // load, independent op, use: one stall
        cyc("l1_load", 1, 1,1, 0,0, 7,1,1, 0,0, 0,0,2'd0,2'd0);
        cyc("l1_ind",  1, 2,1, 0,0, 9,1,0, 0,0, 0,1,2'd0,2'd0);
        cyc("l1_st",   1, 7,1, 1,1, 8,1,0, 0,0, 1,1,2'd0,2'd0);
        cyc("l1_iss",  1, 7,1, 1,1, 8,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("l1_exe", 1, 2'd2, 2'd0);
        nop("l1_c1",  0, 2'd0, 2'd0);
        nop("l1_c2",  0, 2'd0, 2'd0);

        // x0 never matches
        cyc("x0_prod", 1, 0,1, 0,0, 0,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("x0_use",  1, 0,1, 0,1, 1,1,0, 0,0, 0,1,2'd0,2'd0);
        nop("x0_exe", 1, 2'd0, 2'd0);
        nop("x0_c1",  0, 2'd0, 2'd0);
        nop("x0_c2",  0, 2'd0, 2'd0);

        // unused src2 index equal to a writer
        cyc("un_prod", 1, 1,1, 0,0, 9,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("un_use",  1, 1,1, 9,0, 10,1,0, 0,0, 0,1,2'd0,2'd0);
        nop("un_exe", 1, 2'd0, 2'd0);
        nop("un_c1",  0, 2'd0, 2'd0);
        nop("un_c2",  0, 2'd0, 2'd0);

        // both sources from different producers
        cyc("bs_p3",  1, 1,1, 0,0, 3,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("bs_p4",  1, 1,1, 0,0, 4,1,0, 0,0, 0,1,2'd0,2'd0);
        cyc("bs_use", 1, 3,1, 4,1, 5,1,0, 0,0, 0,1,2'd0,2'd0);
        nop("bs_exe", 1, 2'd2, 2'd1);
        nop("bs_c1",  0, 2'd0, 2'd0);
        nop("bs_c2",  0, 2'd0, 2'd0);

        // flush during a load-use stall
        cyc("fl_load", 1, 1,1, 0,0, 7,1,1, 0,0, 0,0,2'd0,2'd0);
        cyc("fl_st",   1, 7,1, 1,1, 8,1,0, 0,0, 1,1,2'd0,2'd0);
        cyc("fl_fl",   1, 7,1, 1,1, 8,1,0, 0,1, 0,0,2'd0,2'd0);
        nop("fl_bub", 0, 2'd0, 2'd0);
        nop("fl_c1",  0, 2'd0, 2'd0);
        nop("fl_c2",  0, 2'd0, 2'd0);

        // hold for 3 cycles mid-sequence
        cyc("hd_p5",  1, 1,1, 0,0, 5,1,0, 0,0, 0,0,2'd0,2'd0);
        cyc("hd_p6",  1, 5,1, 5,1, 6,1,0, 0,0, 0,1,2'd0,2'd0);
        cyc("hd_h1",  1, 6,1, 5,1, 7,1,0, 1,0, 0,1,2'd1,2'd1);
        cyc("hd_h2",  1, 6,1, 5,1, 7,1,0, 1,0, 0,1,2'd1,2'd1);
        cyc("hd_h3",  1, 6,1, 5,1, 7,1,0, 1,0, 0,1,2'd1,2'd1);
        cyc("hd_go",  1, 6,1, 5,1, 7,1,0, 0,0, 0,1,2'd1,2'd1);
        nop("hd_exe", 1, 2'd1, 2'd2);
        nop("hd_c1",  0, 2'd0, 2'd0);
        nop("hd_c2",  0, 2'd0, 2'd0);
        nop("hd_c3",  0, 2'd0, 2'd0);

        // hold while a load-use stall is pending
        cyc("hl_load", 1, 1,1, 0,0, 7,1,1, 0,0, 0,0,2'd0,2'd0);
        cyc("hl_h1",   1, 7,1, 1,1, 8,1,0, 1,0, 1,1,2'd0,2'd0);
        cyc("hl_h2",   1, 7,1, 1,1, 8,1,0, 1,0, 1,1,2'd0,2'd0);
        cyc("hl_st1",  1, 7,1, 1,1, 8,1,0, 0,0, 1,1,2'd0,2'd0);
        cyc("hl_st2",  1, 7,1, 1,1, 8,1,0, 0,0, 1,0,2'd0,2'd0);
        cyc("hl_iss",  1, 7,1, 1,1, 8,1,0, 0,0, 0,0,2'd0,2'd0);
        nop("hl_exe", 1, 2'd2, 2'd0);
        nop("hl_c1",  0, 2'd0, 2'd0);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain actual=%0d required=0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
